// File: rtl/parking_count_scheduler_pkg.sv
// Shared types for the parking occupancy scheduler: FSM states and requester ids.
package parking_count_scheduler_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  localparam logic REQ_ENTRY = 1'b0;
  localparam logic REQ_EXIT  = 1'b1;

endpackage

// File: rtl/parking_count_scheduler_full_adder.sv
// Single-bit full adder cell; used as the bit-serial ALU of the scheduler.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/parking_count_scheduler.sv
// Lot occupancy counter: round-robin between entry/exit gates, +1/-1 applied
// LSB-first through one shared full adder over WIDTH cycles.
module parking_count_scheduler
  import parking_count_scheduler_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int CAPACITY = 200
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             entry_req,
  input  logic             exit_req,
  output logic             entry_ack,
  output logic             exit_ack,
  output logic             entry_deny,
  output logic             exit_deny,
  output logic [WIDTH-1:0] count,
  output logic             full,
  output logic             empty,
  output logic             busy
);

  localparam int BW = $clog2(WIDTH + 1);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] acc_sr, op_sr;
  logic             carry;
  logic [BW-1:0]    bit_cnt;
  logic             rr_last;
  logic             grant;
  logic             req_any, grant_nxt, blocked;
  logic             sum, cout;

  assign full  = (count == WIDTH'(CAPACITY));
  assign empty = (count == '0);

  // Contended requests go to whoever was not served last.
  assign req_any   = entry_req | exit_req;
  assign grant_nxt = (entry_req && exit_req) ? ~rr_last :
                     (entry_req ? REQ_ENTRY : REQ_EXIT);
  assign blocked   = (grant_nxt == REQ_ENTRY) ? full : empty;

  full_adder u_fa (
    .a    (acc_sr[0]),
    .b    (op_sr[0]),
    .cin  (carry),
    .s    (sum),
    .cout (cout)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:  if (req_any && !blocked) state_nxt = ST_SHIFT;
      ST_SHIFT: if (bit_cnt == BW'(WIDTH - 1)) state_nxt = ST_DONE;
      ST_DONE:  state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    entry_ack = (state == ST_DONE) && (grant == REQ_ENTRY);
    exit_ack  = (state == ST_DONE) && (grant == REQ_EXIT);
    busy      = (state == ST_SHIFT) || (state == ST_DONE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count      <= '0;
      acc_sr     <= '0;
      op_sr      <= '0;
      carry      <= 1'b0;
      bit_cnt    <= '0;
      rr_last    <= REQ_EXIT;
      grant      <= REQ_ENTRY;
      entry_deny <= 1'b0;
      exit_deny  <= 1'b0;
    end else begin
      entry_deny <= 1'b0;
      exit_deny  <= 1'b0;
      case (state)
        ST_IDLE: if (req_any) begin
          rr_last <= grant_nxt;
          grant   <= grant_nxt;
          if (blocked) begin
            entry_deny <= (grant_nxt == REQ_ENTRY);
            exit_deny  <= (grant_nxt == REQ_EXIT);
          end else begin
            acc_sr  <= count;
            // Exit adds two's-complement -1; the final carry-out is dropped.
            op_sr   <= (grant_nxt == REQ_ENTRY) ? WIDTH'(1) : '1;
            carry   <= 1'b0;
            bit_cnt <= '0;
          end
        end
        ST_SHIFT: begin
          acc_sr  <= {sum, acc_sr[WIDTH-1:1]};
          op_sr   <= {1'b0, op_sr[WIDTH-1:1]};
          carry   <= cout;
          bit_cnt <= bit_cnt + 1'b1;
        end
        ST_DONE: count <= acc_sr;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_parking_count_scheduler.sv
// Scoreboard bench: the driver predicts each gate outcome, its cycle and the
// resulting count; a negedge monitor pops and compares every ack/deny pulse.
module tb_parking_count_scheduler;

  localparam int W   = 8;
  localparam int CAP = 200;

  // kind: 0 entry_ack, 1 exit_ack, 2 entry_deny, 3 exit_deny
  typedef struct {
    int kind;
    int cnt;
    int due;
  } exp_t;

  logic         clk, rst_n;
  logic         entry_req, exit_req;
  logic         entry_ack, exit_ack, entry_deny, exit_deny;
  logic [W-1:0] count;
  logic         full, empty, busy;

  exp_t sbq[$];
  int   m_count;
  bit   m_rr_exit;
  int   cyc;
  int   n_chk, n_fail;
  bit   cnt_pend;
  int   cnt_exp;
  bit   timeout_hit, timeout_seen, end_req;

  parking_count_scheduler #(.WIDTH(W), .CAPACITY(CAP)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .entry_req  (entry_req),
    .exit_req   (exit_req),
    .entry_ack  (entry_ack),
    .exit_ack   (exit_ack),
    .entry_deny (entry_deny),
    .exit_deny  (exit_deny),
    .count      (count),
    .full       (full),
    .empty      (empty),
    .busy       (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: serve the pending gates one at a time starting from IDLE-sample
  // cycle t. An accepted op finishes W+1 cycles later and the lot is idle again
  // one cycle after that; a refusal shows next cycle, already idle.
  function automatic int model_serve(bit e, bit x, int t);
    int  tt;
    bit  pe, px, g_exit;
    tt = t; pe = e; px = x;
    while (pe || px) begin
      if (pe && px) g_exit = !m_rr_exit;
      else          g_exit = px;
      m_rr_exit = g_exit;
      if (!g_exit) begin
        pe = 1'b0;
        if (m_count == CAP) begin
          sbq.push_back('{2, m_count, tt + 1}); tt = tt + 1;
        end else begin
          m_count++;
          sbq.push_back('{0, m_count, tt + W + 1}); tt = tt + W + 2;
        end
      end else begin
        px = 1'b0;
        if (m_count == 0) begin
          sbq.push_back('{3, m_count, tt + 1}); tt = tt + 1;
        end else begin
          m_count--;
          sbq.push_back('{1, m_count, tt + W + 1}); tt = tt + W + 2;
        end
      end
    end
    return tt;
  endfunction

  // Raise the requests, drop each one when its ack/deny is seen. A nonzero
  // x_delay raises exit that many cycles after entry.
  task automatic run_txn(input bit e, input bit x, input int x_delay);
    int t, k;
    bit x_pend;
    @(negedge clk);
    x_pend    = x && (x_delay > 0);
    entry_req = e;
    exit_req  = x && !x_pend;
    t = model_serve(e, x && !x_pend, cyc);
    k = 0;
    while ((entry_req || exit_req || x_pend) && k < 300) begin
      @(negedge clk);
      k++;
      if (entry_ack || entry_deny) entry_req = 1'b0;
      if (exit_ack || exit_deny)   exit_req  = 1'b0;
      if (x_pend && k == x_delay) begin
        exit_req = 1'b1;
        x_pend   = 1'b0;
        void'(model_serve(1'b0, 1'b1, (t > cyc) ? t : cyc));
      end
    end
    if (k >= 300) begin
      timeout_hit = 1'b1;
      entry_req   = 1'b0;
      exit_req    = 1'b0;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    int   np, kind;
    np = int'(entry_ack) + int'(exit_ack) + int'(entry_deny) + int'(exit_deny);
    if (!rst_n) begin
      chk("reset_count", int'(count), 0);
      chk("reset_empty", int'(empty), 1);
      chk("reset_full", int'(full), 0);
      chk("reset_busy", int'(busy), 0);
      chk("reset_pulses", np, 0);
      cnt_pend = 1'b0;
    end else begin
      if (cnt_pend) begin
        chk("count", int'(count), cnt_exp);
        chk("full", int'(full), int'(cnt_exp == CAP));
        chk("empty", int'(empty), int'(cnt_exp == 0));
        cnt_pend = 1'b0;
      end
      if (np > 0) begin
        kind = entry_ack ? 0 : exit_ack ? 1 : entry_deny ? 2 : 3;
        chk("single_pulse", np, 1);
        if (sbq.size() == 0) begin
          chk("unexpected_pulse_kind", kind, -1);
        end else begin
          e = sbq.pop_front();
          chk("pulse_kind", kind, e.kind);
          chk("pulse_cycle", cyc, e.due);
          chk("busy_at_pulse", int'(busy), int'(e.kind < 2));
          cnt_pend = 1'b1;
          cnt_exp  = e.cnt;
        end
      end
    end
    if (timeout_hit && !timeout_seen) begin
      timeout_seen = 1'b1;
      chk("txn_timeout", 1, 0);
    end
    if (end_req) begin
      chk("scoreboard_drained", sbq.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
    end
  end

  initial begin
    n_chk = 0; n_fail = 0; cnt_pend = 1'b0;
    timeout_hit = 1'b0; timeout_seen = 1'b0; end_req = 1'b0;
    m_count = 0; m_rr_exit = 1'b1;
    entry_req = 1'b0; exit_req = 1'b0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;

    // exit at empty is refused
    run_txn(1'b0, 1'b1, 0);

    // reset lands in the third SHIFT cycle of an entry
    @(negedge clk);
    entry_req = 1'b1;
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    entry_req = 1'b0;
    m_count = 0; m_rr_exit = 1'b1;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    run_txn(1'b1, 1'b0, 0);

    // carry / borrow chains across 0x0F <-> 0x10
    while (m_count < 15) run_txn(1'b1, 1'b0, 0);
    run_txn(1'b1, 1'b0, 0);
    run_txn(1'b0, 1'b1, 0);

    // exit arrives mid-SHIFT of an entry
    run_txn(1'b1, 1'b1, 4);

    // both held at count 5: entry, exit, then entry again
    while (m_count > 5) run_txn(1'b0, 1'b1, 0);
    run_txn(1'b1, 1'b1, 0);
    run_txn(1'b1, 1'b1, 0);

    // randomized mix
    for (int i = 0; i < 40; i++) begin
      bit e, x;
      int d;
      e = 1'($urandom_range(0, 1));
      x = 1'($urandom_range(0, 1));
      if (!e && !x) e = 1'b1;
      d = (e && x && $urandom_range(0, 1) == 1) ? int'($urandom_range(1, 12)) : 0;
      run_txn(e, x, d);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // fill to capacity, refuse one more, then free a space
    while (m_count < CAP) run_txn(1'b1, 1'b0, 0);
    run_txn(1'b1, 1'b0, 0);
    run_txn(1'b1, 1'b1, 0);
    run_txn(1'b0, 1'b1, 0);

    repeat (3) @(negedge clk);
    end_req = 1'b1;
  end

endmodule
